// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for a MIPS-style pipeline.
// It owns the architectural HI/LO registers. mult/multu/div/divu compute
// their 64-bit result as soon as they start, hold it in a pending register,
// and keep the unit busy for a fixed number of cycles before committing it
// to HI/LO. mthi/mtlo write HI/LO in a single cycle.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        read_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      pending_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic             busy_reg;

  // Decoded request classes.
  logic is_long_op;
  logic is_div_op;
  assign is_long_op = (op == OP_MULT) || (op == OP_MULTU) ||
                      (op == OP_DIV)  || (op == OP_DIVU);
  assign is_div_op  = (op == OP_DIV)  || (op == OP_DIVU);

  // Result datapath signals.
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] mul_prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_div;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] pending_next;
  logic [CNT_W-1:0] cnt_load;

  // Build the 64-bit result of the requested long operation from the live operands.
  always_comb begin
    mul_a_ext    = '0;
    mul_b_ext    = '0;
    mul_prod     = '0;
    a_neg        = 1'b0;
    b_neg        = 1'b0;
    abs_a        = src_a;
    abs_b        = src_b;
    safe_div     = 32'd1;
    uquot        = '0;
    urem         = '0;
    quot         = '0;
    rem          = '0;
    pending_next = {hi_reg, lo_reg};
    cnt_load     = CNT_W'(MULT_CYCLES);

    // Multiplier: sign- or zero-extend to 64 bits, keep the low 64 bits of the product.
    if (op == OP_MULT) begin
      mul_a_ext = {{32{src_a[31]}}, src_a};
      mul_b_ext = {{32{src_b[31]}}, src_b};
    end else begin
      mul_a_ext = {32'd0, src_a};
      mul_b_ext = {32'd0, src_b};
    end
    mul_prod = mul_a_ext * mul_b_ext;

    // Divider: work on magnitudes, then restore signs. The quotient takes the
    // XOR of operand signs, the remainder takes the dividend's sign. The
    // 0x80000000 / -1 case falls out naturally as 0x80000000 remainder 0.
    if (op == OP_DIV) begin
      a_neg = src_a[31];
      b_neg = src_b[31];
    end
    abs_a    = a_neg ? (32'd0 - src_a) : src_a;
    abs_b    = b_neg ? (32'd0 - src_b) : src_b;
    safe_div = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uquot    = abs_a / safe_div;
    urem     = abs_a % safe_div;
    quot     = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem      = a_neg ? (32'd0 - urem) : urem;

    if (is_div_op) begin
      cnt_load = CNT_W'(DIV_CYCLES);
      // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
      if (src_b != 32'd0) begin
        pending_next = {rem, quot};
      end
    end else begin
      pending_next = mul_prod;
    end
  end

  // Two-state control FSM owning the counter, pending result and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (is_long_op) begin
              pending_reg <= pending_next;
              cnt_reg     <= cnt_load;
              state_reg   <= BUSY;
              busy_reg    <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi_reg <= src_a;
            end else if (op == OP_MTLO) begin
              lo_reg <= src_a;
            end
          end
        end
        BUSY: begin
          // New starts are ignored here; the in-flight result is already latched.
          if (cnt_reg == CNT_W'(1)) begin
            hi_reg    <= pending_reg[63:32];
            lo_reg    <= pending_reg[31:0];
            cnt_reg   <= '0;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign stall_req = busy_reg | (start & is_long_op);
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign rd_data   = read_sel ? hi_reg : lo_reg;

endmodule
